// File: rtl/stream_demux.sv
// ============================================================================
// Module   : stream_demux
// Purpose  : Registered 1-to-N valid/ready stream demultiplexer with one
//            output register per lane. Round-robin lane order by default;
//            define STREAM_DEMUX_SEL_EN for per-beat lane select via up_sel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  output logic               up_ready,
`ifdef STREAM_DEMUX_SEL_EN
  input  logic [SEL_W-1:0]   up_sel,
`endif
  output logic [N-1:0]       down_valid,
  output logic [N*WIDTH-1:0] down_data,
  input  logic [N-1:0]       down_ready
);

  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0]        w_tgt;
  logic                    w_tgt_ok;
  logic                    w_accept;

`ifdef STREAM_DEMUX_SEL_EN
  assign w_tgt = up_sel;
`else
  logic [SEL_W-1:0] ptr_q, ptr_d;
  assign w_tgt = ptr_q;
`endif

  // Out-of-range selects (non-power-of-2 N) never accept.
  assign w_tgt_ok = int'(w_tgt) < N;
  assign up_ready = w_tgt_ok & (~valid_q[w_tgt] | down_ready[w_tgt]);
  assign w_accept = up_valid & up_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < N; i++) begin
      if (w_accept && (w_tgt == SEL_W'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = up_data;
      end else if (down_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

`ifndef STREAM_DEMUX_SEL_EN
  always_comb begin
    ptr_d = ptr_q;
    if (w_accept) begin
      ptr_d = (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + SEL_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
`ifndef STREAM_DEMUX_SEL_EN
      ptr_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifndef STREAM_DEMUX_SEL_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign down_valid = valid_q;
  assign down_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// Module   : tb_stream_demux
// Purpose  : Self-checking bench for stream_demux against a lane-array model;
//            honours STREAM_DEMUX_SEL_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic               up_valid;
  logic [WIDTH-1:0]   up_data;
  logic               up_ready;
  logic [SW-1:0]      up_sel;
  logic [N-1:0]       down_valid;
  logic [N*WIDTH-1:0] down_data;
  logic [N-1:0]       down_ready;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
`ifdef STREAM_DEMUX_SEL_EN
    .up_sel     (up_sel),
`endif
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic             m_valid [N];
  logic [WIDTH-1:0] m_data  [N];
  int               m_ptr;
  logic             last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_ptr = 0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                      input logic [SW-1:0] s, input logic [N-1:0] rdy);
    int                 tgt;
    logic               exp_rdy;
    logic [N-1:0]       mv;
    logic [N*WIDTH-1:0] md;
    rst = r; up_valid = v; up_data = d; up_sel = s; down_ready = rdy;
    #1;
`ifdef STREAM_DEMUX_SEL_EN
    tgt = int'(s);
`else
    tgt = m_ptr;
`endif
    exp_rdy = 1'b0;
    if (tgt < N) exp_rdy = !m_valid[tgt] || rdy[tgt];
    for (int i = 0; i < N; i++) begin
      mv[i] = m_valid[i];
      md[i*WIDTH +: WIDTH] = m_data[i];
    end
    chk("down_valid", 64'(down_valid), 64'(mv));
    chk("down_data",  64'(down_data),  64'(md));
    chk("up_ready",   64'(up_ready),   64'(exp_rdy));
    last_ready = up_ready;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v && exp_rdy && i == tgt) begin
          m_valid[i] = 1'b1;
          m_data[i]  = d;
        end else if (rdy[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (v && exp_rdy) m_ptr = (m_ptr + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [N-1:0] rdy);
    step(1'b0, 1'b1, d, SW'(m_ptr), rdy);
  endtask

  task automatic idle(input logic [N-1:0] rdy);
    step(1'b0, 1'b0, '0, SW'(m_ptr), rdy);
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_sel = '0; down_ready = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(down_valid), 64'h0);
    chk("reset_data",  64'(down_data),  64'h0);
    chk("reset_ready", 64'(up_ready),   64'h1);

    // Back-to-back round robin with all consumers ready
    for (int k = 0; k < 5; k++) begin
      send(8'h10 + 8'(k), 4'hF);
      chk("rr_ready", 64'(last_ready), 64'h1);
    end
    chk("rr_valid", 64'(down_valid), 64'h1);
    chk("rr_data",  64'(down_data),  64'h13121114);

    // Fill all lanes, then stall until lane 0 drains
    step(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 4'h0);
    chk("full_valid", 64'(down_valid), 64'hF);
    chk("full_data",  64'(down_data),  64'hA3A2A1A0);
    send(8'hA4, 4'h0);
    chk("stall_ready", 64'(last_ready), 64'h0);
    send(8'hA4, 4'h1);
    chk("drain_load_ready", 64'(last_ready), 64'h1);
    chk("drain_load_data",  64'(down_data),  64'hA3A2A1A4);
    chk("drain_load_valid", 64'(down_valid), 64'hF);

    // No skip: lane 1 stalled while lanes 2,3 empty
    idle(4'b1100);
    send(8'h77, 4'h0);
    chk("noskip_ready", 64'(last_ready), 64'h0);
    chk("noskip_valid", 64'(down_valid), 64'h3);

    // Hold lane 1 data while its consumer stalls
    idle(4'b0010);
    send(8'h55, 4'h0);
    for (int k = 0; k < 5; k++) begin
      idle(4'h0);
      chk("hold_data",  64'(down_data[15:8]), 64'h55);
      chk("hold_valid", 64'(down_valid[1]),   64'h1);
    end

    // Mid-operation reset with lanes 0,2 full and pointer at 3
    send(8'h66, 4'b0010);
    chk("pre_rst_valid", 64'(down_valid), 64'h5);
    step(1'b1, 1'b1, 8'h99, SW'(m_ptr), 4'h0);
    chk("rst_valid", 64'(down_valid), 64'h0);
    chk("rst_data",  64'(down_data),  64'h0);
    send(8'h42, 4'h0);
    chk("post_rst_valid", 64'(down_valid), 64'h1);
    chk("post_rst_data",  64'(down_data),  64'h42);

`ifdef STREAM_DEMUX_SEL_EN
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 8'h01, 2'd2, 4'h0);
    step(1'b0, 1'b1, 8'h02, 2'd2, 4'h0);
    chk("sel_stall", 64'(last_ready), 64'h0);
    step(1'b0, 1'b1, 8'h02, 2'd2, 4'b0100);
    chk("sel_reload", 64'(last_ready), 64'h1);
    step(1'b0, 1'b1, 8'h03, 2'd0, 4'h0);
    chk("sel_valid", 64'(down_valid), 64'h5);
    chk("sel_data",  64'(down_data),  64'h00020003);
`endif

    // Randomized traffic with varying consumer back-pressure
    for (int k = 0; k < 3000; k++) begin
      logic          r;
      logic          v;
      logic [SW-1:0] s;
      logic [N-1:0]  rdy;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = (k % 500 < 250) ? N'($urandom) : N'($urandom & $urandom);
`ifdef STREAM_DEMUX_SEL_EN
      s = SW'($urandom_range(0, (1 << SW) - 1));
`else
      s = SW'(m_ptr);
`endif
      step(r, v, WIDTH'($urandom), s, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
